mtl_pixel_prefetch: RTL and testbench
=====================================

Name: mtl_pixel_prefetch

Overview:
- Upstream feeder for the MTL LCD timing generator.
- Streams one frame of 32-bit RGB pixels from the SDRAM/MMU read port into a show-ahead FIFO, starting from a per-frame base address.
- The display consumes pixels by asserting a pop. iREAD_DATA is valid in the same cycle as the pop.
- Restarts on the display's new-frame pulse. Handles abort, underflow and in-flight read draining.

Parameters:
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 480, active lines per frame
- DEPTH, 512, FIFO depth in 32-bit words (power of 2)
- ADDR_W, 24, memory word-address width
- MAX_OUTSTANDING, 8, maximum accepted-but-unreturned reads
- UNDERFLOW_COLOR, 32'h00FF00FF, pixel driven on a pop while the FIFO is empty

Ports:
- iCLK  in  1  pixel/system clock
- iRST  in  1  synchronous reset, active-high
- iNew_Frame  in  1  one-cycle pulse from the display at the frame start
- iFrame_Base  in  ADDR_W  frame buffer base address, latched on iNew_Frame
- iPop  in  1  display pixel request (display's next_display_active)
- oREAD_DATA  out  32  pixel to display: FIFO head, or UNDERFLOW_COLOR when empty
- oMEM_ADDR  out  ADDR_W  read address
- oMEM_READ  out  1  read request
- iMEM_WAIT  in  1  waitrequest; the request is held while it is high
- iMEM_VALID  in  1  read data valid
- iMEM_DATA  in  32  read data
- oFIFO_LEVEL  out  log2(DEPTH)+1  current FIFO occupancy
- oUnderflow  out  1  sticky; set on a pop while empty, cleared on iNew_Frame

Behaviour:
- Clock and reset: one clock, iCLK. Reset iRST is synchronous and active-high.
- Reset values: state=IDLE, FIFO empty, oMEM_READ=0, oMEM_ADDR=0, oUnderflow=0, oFIFO_LEVEL=0, outstanding=0, req_cnt=0.
- FSM states: IDLE, DRAIN, FETCH, DONE.
  - IDLE: wait for iNew_Frame.
  - On iNew_Frame from any state:
    - latch base_addr=iFrame_Base, req_cnt=0, oUnderflow=0.
    - empty the FIFO in that cycle. A pop in the same cycle returns the old head and is then discarded.
    - go to DRAIN if outstanding!=0, else FETCH.
  - DRAIN: oMEM_READ=0. Returning iMEM_VALID words are dropped and outstanding is decremented. When outstanding reaches 0 (or is already 0), go to FETCH next cycle.
  - FETCH:
    - Assert oMEM_READ when credit = DEPTH - level - outstanding > 0 and outstanding < MAX_OUTSTANDING.
    - oMEM_ADDR = base_addr + req_cnt.
    - Request accepted when oMEM_READ && !iMEM_WAIT: req_cnt++ and outstanding++.
    - While iMEM_WAIT is high, address and read stay stable.
    - When req_cnt == H_ACTIVE*V_ACTIVE (384000, 19-bit counter) after an acceptance, go to DONE.
  - DONE: oMEM_READ=0. Returns are still written into the FIFO. Wait for iNew_Frame.
- Outstanding counter: +1 on acceptance, -1 on iMEM_VALID, net 0 when both occur in the same cycle.
- FIFO writes: an iMEM_VALID word is written in FETCH/DONE only. It is never dropped, because the credit rule guarantees space.
- FIFO reads:
  - A pop with level>0 removes the head; oREAD_DATA shows the new head in the next cycle.
  - Simultaneous push and pop leave the level unchanged. A push into an empty FIFO is visible on oREAD_DATA in the next cycle.
  - A pop with level==0: oREAD_DATA=UNDERFLOW_COLOR, oUnderflow set, no pointer change.
  - oREAD_DATA is UNDERFLOW_COLOR whenever the FIFO is empty.
- Address arithmetic: modulo 2^ADDR_W; wraps silently.
- Reset during any operation: return to the reset values next cycle. Any in-flight memory returns after reset are ignored, because outstanding=0 and the state is IDLE.

Optional Feature:
- Macro: MTL_PREFETCH_STATS_EN.
- When defined, add two outputs:
  - oUnderflow_cnt (16 bits): counts pops while empty, saturates at 16'hFFFF, cleared on iNew_Frame and reset.
  - oMin_Level (log2(DEPTH)+1 bits): minimum oFIFO_LEVEL seen since the last iNew_Frame. It is set to DEPTH on iNew_Frame.
- When not defined, neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Basic fetch: reset, iFrame_Base=24'h001000, pulse iNew_Frame, memory with 3-cycle latency and iMEM_WAIT=0 -> first oMEM_ADDR=24'h001000, addresses increment by 1, level rises to 512 and stops, outstanding never exceeds 8.
- Pop ordering: with memory returning data equal to the address, pop 800 consecutive cycles -> oREAD_DATA sequence is 0x1000..0x131F with no gaps, oUnderflow=0.
- Waitrequest: hold iMEM_WAIT=1 for 5 cycles on the 10th request -> oMEM_ADDR=0x1009 stable for all 5 cycles, no duplicate or skipped address.
- Underflow: pop on an empty FIFO right after iNew_Frame -> oREAD_DATA=32'h00FF00FF, oUnderflow=1. A second iNew_Frame clears it; with STATS, oUnderflow_cnt counts 1 per pop.
- Mid-frame restart: iNew_Frame with 4 reads outstanding -> state DRAIN, those 4 returns are dropped, the next request is at the new base, and the FIFO contains only new-frame data.
- Frame end: complete 384000 accepted requests -> oMEM_READ deasserts permanently until the next iNew_Frame; a synchronous iRST mid-FETCH gives oMEM_READ=0 and oFIFO_LEVEL=0 on the next cycle.

Source files
------------

// File: rtl/mtl_pixel_prefetch.sv
// mtl_pixel_prefetch: streams one frame of 32-bit pixels from the memory read
// port into a show-ahead FIFO that feeds the MTL LCD timing generator.
// Optional statistics outputs (oUnderflow_cnt, oMin_Level) are present only
// when the macro MTL_PREFETCH_STATS_EN is defined.
module mtl_pixel_prefetch #(
    parameter int unsigned H_ACTIVE        = 800,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned DEPTH           = 512,
    parameter int unsigned ADDR_W          = 24,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter logic [31:0] UNDERFLOW_COLOR = 32'h00FF00FF
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iNew_Frame,
    input  logic [ADDR_W-1:0]       iFrame_Base,
    input  logic                    iPop,
    output logic [31:0]             oREAD_DATA,
    output logic [ADDR_W-1:0]       oMEM_ADDR,
    output logic                    oMEM_READ,
    input  logic                    iMEM_WAIT,
    input  logic                    iMEM_VALID,
    input  logic [31:0]             iMEM_DATA,
    output logic [$clog2(DEPTH):0]  oFIFO_LEVEL,
    output logic                    oUnderflow
`ifdef MTL_PREFETCH_STATS_EN
    ,
    output logic [15:0]             oUnderflow_cnt,
    output logic [$clog2(DEPTH):0]  oMin_Level
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SUM_W = ((LVL_W > OUT_W) ? LVL_W : OUT_W) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FETCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [31:0]        fifoMem [DEPTH];
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [LVL_W-1:0]   level;
    logic [OUT_W-1:0]   outstanding;
    logic [OUT_W-1:0]   outstandingNext;
    logic [CNT_W-1:0]   reqCnt;
    logic [ADDR_W-1:0]  memAddr;
    logic               underflow;
    logic               memRead;
    logic               memAccept;
    logic               memRet;
    logic               push;
    logic               popEff;
    logic               fifoEmpty;
    logic               canIssue;

    assign fifoEmpty = (level == '0);
    // Credit: free FIFO slots not already promised to in-flight reads
    assign canIssue  = ((SUM_W'(level) + SUM_W'(outstanding)) < SUM_W'(DEPTH)) &&
                       (outstanding < OUT_W'(MAX_OUTSTANDING));
    assign memAccept = memRead && !iMEM_WAIT;
    // A return with nothing outstanding belongs to a read issued before reset
    assign memRet    = iMEM_VALID && (outstanding != '0);
    assign push      = memRet && !iNew_Frame && ((state == FETCH) || (state == DONE));
    assign popEff    = iPop && !fifoEmpty && !iNew_Frame;

    assign oREAD_DATA  = fifoEmpty ? UNDERFLOW_COLOR : fifoMem[rdPtr];
    assign oMEM_ADDR   = memAddr;
    assign oMEM_READ   = memRead;
    assign oFIFO_LEVEL = level;
    assign oUnderflow  = underflow;

    // In-flight read count after this cycle's acceptance and return
    always_comb begin
        outstandingNext = outstanding;
        if (memAccept && !memRet) begin
            outstandingNext = outstanding + OUT_W'(1);
        end else if (!memAccept && memRet) begin
            outstandingNext = outstanding - OUT_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next-state logic; a new frame restarts from any state
    always_comb begin
        stateNext = state;
        if (iNew_Frame) begin
            stateNext = (outstandingNext != '0) ? DRAIN : FETCH;
        end else begin
            unique case (state)
                IDLE:    stateNext = IDLE;
                DRAIN:   if (outstandingNext == '0) stateNext = FETCH;
                FETCH:   if (memAccept && (reqCnt == CNT_W'(TOTAL - 1))) stateNext = DONE;
                DONE:    stateNext = DONE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // FSM outputs: reads are requested only while fetching and credit allows
    always_comb begin
        memRead = 1'b0;
        unique case (state)
            FETCH:   memRead = canIssue;
            default: memRead = 1'b0;
        endcase
    end

    // In-flight read counter
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            outstanding <= '0;
        end else begin
            outstanding <= outstandingNext;
        end
    end

    // Request address, frame progress, FIFO pointers/level and underflow flag
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            memAddr   <= '0;
            reqCnt    <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            level     <= '0;
            underflow <= 1'b0;
        end else if (iNew_Frame) begin
            memAddr   <= iFrame_Base;
            reqCnt    <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            level     <= '0;
            underflow <= 1'b0;
        end else begin
            if (memAccept) begin
                memAddr <= memAddr + ADDR_W'(1);
                reqCnt  <= reqCnt + CNT_W'(1);
            end
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (popEff) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (push && !popEff) begin
                level <= level + LVL_W'(1);
            end else if (!push && popEff) begin
                level <= level - LVL_W'(1);
            end
            if (iPop && fifoEmpty) begin
                underflow <= 1'b1;
            end
        end
    end

    // FIFO storage, no reset needed: validity is tracked by the pointers
    always_ff @(posedge iCLK) begin
        if (push) begin
            fifoMem[wrPtr] <= iMEM_DATA;
        end
    end

`ifdef MTL_PREFETCH_STATS_EN
    logic [15:0]      underflowCnt;
    logic [LVL_W-1:0] minLevel;

    assign oUnderflow_cnt = underflowCnt;
    assign oMin_Level     = minLevel;

    // Per-frame underflow count (saturating) and low-water mark of the FIFO
    always_ff @(posedge iCLK) begin
        if (iRST || iNew_Frame) begin
            underflowCnt <= '0;
            minLevel     <= LVL_W'(DEPTH);
        end else begin
            if (iPop && fifoEmpty && (underflowCnt != 16'hFFFF)) begin
                underflowCnt <= underflowCnt + 16'd1;
            end
            if (level < minLevel) begin
                minLevel <= level;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mtl_pixel_prefetch.sv
// Directed bench for mtl_pixel_prefetch using a reduced frame (10x4) and a
// 16-deep FIFO; the memory model returns data equal to the read address.
module tb_mtl_pixel_prefetch;

    localparam int unsigned H      = 10;
    localparam int unsigned V      = 4;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned MAXO   = 8;
    localparam int unsigned TOTAL  = H * V;
    localparam logic [31:0] UCOL   = 32'h00FF00FF;

    logic              iCLK = 1'b0;
    logic              iRST;
    logic              iNew_Frame;
    logic [ADDR_W-1:0] iFrame_Base;
    logic              iPop;
    logic [31:0]       oREAD_DATA;
    logic [ADDR_W-1:0] oMEM_ADDR;
    logic              oMEM_READ;
    logic              iMEM_WAIT;
    logic              iMEM_VALID;
    logic [31:0]       iMEM_DATA;
    logic [4:0]        oFIFO_LEVEL;
    logic              oUnderflow;
`ifdef MTL_PREFETCH_STATS_EN
    logic [15:0]       oUnderflow_cnt;
    logic [4:0]        oMin_Level;
`endif

    int total  = 0;
    int bad    = 0;
    int tbOut  = 0;
    int maxOut = 0;
    int maxLvl = 0;
    logic [ADDR_W-1:0] accQ [$];

    mtl_pixel_prefetch #(
        .H_ACTIVE(H), .V_ACTIVE(V), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .MAX_OUTSTANDING(MAXO), .UNDERFLOW_COLOR(UCOL)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iNew_Frame(iNew_Frame), .iFrame_Base(iFrame_Base),
        .iPop(iPop), .oREAD_DATA(oREAD_DATA), .oMEM_ADDR(oMEM_ADDR), .oMEM_READ(oMEM_READ),
        .iMEM_WAIT(iMEM_WAIT), .iMEM_VALID(iMEM_VALID), .iMEM_DATA(iMEM_DATA),
        .oFIFO_LEVEL(oFIFO_LEVEL), .oUnderflow(oUnderflow)
`ifdef MTL_PREFETCH_STATS_EN
        , .oUnderflow_cnt(oUnderflow_cnt), .oMin_Level(oMin_Level)
`endif
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitAcc(input int n, input int budget);
        int c = 0;
        while (accQ.size() < n && c < budget) begin
            @(negedge iCLK);
            c++;
        end
        check("wait_accepts", 32'(accQ.size() >= n), 32'd1);
    endtask

    function automatic int seqErrs(input int s, input int n, input logic [ADDR_W-1:0] base);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            if ((s + i) >= accQ.size()) e++;
            else if (accQ[s + i] !== base + ADDR_W'(i)) e++;
        end
        return e;
    endfunction

    task automatic popSeq(input string tag, input logic [ADDR_W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, oREAD_DATA, {8'h00, base + ADDR_W'(i)});
            iPop = 1'b1;
            @(negedge iCLK);
        end
        iPop = 1'b0;
    endtask

    task automatic pulseFrame(input logic [ADDR_W-1:0] base);
        iFrame_Base = base;
        iNew_Frame  = 1'b1;
        @(negedge iCLK);
        iNew_Frame  = 1'b0;
    endtask

    // Memory: 4-edge read latency, data = address, bookkeeping of accepted reads
    initial begin : memModel
        logic              pv [3];
        logic [31:0]       pd [3];
        logic              acc;
        logic              vld;
        logic              dec;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        iMEM_VALID = 1'b0;
        iMEM_DATA  = '0;
        forever begin
            @(negedge iCLK);
            #4;
            acc = (iRST !== 1'b0) ? 1'b0 : (oMEM_READ === 1'b1) && (iMEM_WAIT === 1'b0);
            a   = oMEM_ADDR;
            vld = iMEM_VALID;
            if (iRST !== 1'b0) begin
                tbOut = 0;
            end else begin
                dec = vld && (tbOut > 0);
                if (acc) begin
                    accQ.push_back(a);
                    tbOut++;
                end
                if (dec) tbOut--;
            end
            if (tbOut > maxOut) maxOut = tbOut;
            if (int'(oFIFO_LEVEL) > maxLvl) maxLvl = int'(oFIFO_LEVEL);
            @(posedge iCLK);
            #1;
            iMEM_VALID = pv[2];
            iMEM_DATA  = pd[2];
            pv[2] = pv[1]; pd[2] = pd[1];
            pv[1] = pv[0]; pd[1] = pd[0];
            pv[0] = acc;   pd[0] = {8'h00, a};
        end
    end

    initial begin : stim
        int s;
        int c;
        int errs;
        iRST = 1'b1; iNew_Frame = 1'b0; iPop = 1'b0; iMEM_WAIT = 1'b0; iFrame_Base = '0;
        repeat (2) @(negedge iCLK);

        // Reset values
        check("rst_read",  32'(oMEM_READ), 32'd0);
        check("rst_addr",  32'(oMEM_ADDR), 32'd0);
        check("rst_level", 32'(oFIFO_LEVEL), 32'd0);
        check("rst_uflow", 32'(oUnderflow), 32'd0);
        check("rst_data",  oREAD_DATA, UCOL);
        iRST = 1'b0;
        repeat (3) @(negedge iCLK);
        check("idle_read", 32'(oMEM_READ), 32'd0);

        // Basic fetch: fills to DEPTH and stops
        pulseFrame(24'h001000);
        check("f1_first_read", 32'(oMEM_READ), 32'd1);
        check("f1_first_addr", 32'(oMEM_ADDR), 32'h001000);
        repeat (40) @(negedge iCLK);
        check("f1_accepts",   32'(accQ.size()), 32'd16);
        check("f1_level",     32'(oFIFO_LEVEL), 32'd16);
        check("f1_read_full", 32'(oMEM_READ), 32'd0);
        check("f1_next_addr", 32'(oMEM_ADDR), 32'h001010);
        check("f1_addr_seq",  32'(seqErrs(0, 16, 24'h001000)), 32'd0);

        // Pop the whole frame back-to-back
        popSeq("f1_pop_data", 24'h001000, int'(TOTAL));
        check("f1_no_uflow",    32'(oUnderflow), 32'd0);
        check("f1_total_acc",   32'(accQ.size()), TOTAL);
        check("f1_all_seq",     32'(seqErrs(0, int'(TOTAL), 24'h001000)), 32'd0);
        check("f1_level_empty", 32'(oFIFO_LEVEL), 32'd0);
        check("f1_empty_data",  oREAD_DATA, UCOL);

        // Frame end: no more requests until a new frame
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            if (oMEM_READ !== 1'b0) errs++;
            @(negedge iCLK);
        end
        check("done_read_low", 32'(errs), 32'd0);
        check("done_acc_hold", 32'(accQ.size()), TOTAL);
        iPop = 1'b1;
        @(negedge iCLK);
        iPop = 1'b0;
        check("done_uflow_set", 32'(oUnderflow), 32'd1);

        // New frame clears underflow; pops on the empty FIFO set it again
        pulseFrame(24'h002000);
        check("f2_uflow_clr", 32'(oUnderflow), 32'd0);
        check("f2_level",     32'(oFIFO_LEVEL), 32'd0);
        check("f2_data_ucol", oREAD_DATA, UCOL);
`ifdef MTL_PREFETCH_STATS_EN
        check("f2_cnt_clr", 32'(oUnderflow_cnt), 32'd0);
`endif
        iPop = 1'b1;
        @(negedge iCLK);
        check("f2_pop_ucol", oREAD_DATA, UCOL);
        @(negedge iCLK);
        iPop = 1'b0;
        check("f2_uflow_set", 32'(oUnderflow), 32'd1);
`ifdef MTL_PREFETCH_STATS_EN
        check("f2_cnt_two", 32'(oUnderflow_cnt), 32'd2);
        check("f2_min_lvl", 32'(oMin_Level), 32'd0);
`endif

        // Mid-frame restart with four reads in flight
        c = 0;
        while (tbOut != 4 && c < 20) begin
            @(negedge iCLK);
            c++;
        end
        check("f2_inflight", 32'(tbOut), 32'd4);
        check("f2_level_pre", 32'(oFIFO_LEVEL), 32'd0);
        pulseFrame(24'h003000);
        s = accQ.size();
        check("f3_drain_read", 32'(oMEM_READ), 32'd0);
        check("f3_level",      32'(oFIFO_LEVEL), 32'd0);
        check("f3_addr",       32'(oMEM_ADDR), 32'h003000);
        check("f3_uflow_clr",  32'(oUnderflow), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge iCLK);
            check("f3_drain_hold", 32'(oMEM_READ), 32'd0);
            check("f3_drop_level", 32'(oFIFO_LEVEL), 32'd0);
        end

        // Waitrequest held on the 10th request of the new frame
        waitAcc(s + 9, 30);
        check("wait_addr0", 32'(oMEM_ADDR), 32'h003009);
        check("wait_read0", 32'(oMEM_READ), 32'd1);
        iMEM_WAIT = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge iCLK);
            check("wait_hold_addr", 32'(oMEM_ADDR), 32'h003009);
            check("wait_hold_read", 32'(oMEM_READ), 32'd1);
        end
        check("wait_no_accept", 32'(accQ.size() - s), 32'd9);
        iMEM_WAIT = 1'b0;
        repeat (30) @(negedge iCLK);
        check("f3_accepts", 32'(accQ.size() - s), 32'd16);
        check("f3_addr_seq", 32'(seqErrs(s, 16, 24'h003000)), 32'd0);
        check("f3_level_full", 32'(oFIFO_LEVEL), 32'd16);
        popSeq("f3_pop_data", 24'h003000, 16);
        check("f3_no_uflow", 32'(oUnderflow), 32'd0);

        // Synchronous reset in the middle of fetching
        iRST = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;
        check("mid_rst_read",  32'(oMEM_READ), 32'd0);
        check("mid_rst_level", 32'(oFIFO_LEVEL), 32'd0);
        check("mid_rst_addr",  32'(oMEM_ADDR), 32'd0);
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge iCLK);
            if (oMEM_READ !== 1'b0 || oFIFO_LEVEL !== 5'd0) errs++;
        end
        check("post_rst_ignore", 32'(errs), 32'd0);

        // Address wraps modulo 2^ADDR_W
        s = accQ.size();
        pulseFrame(24'hFFFFFE);
        waitAcc(s + 3, 20);
        check("wrap_seq", 32'(seqErrs(s, 3, 24'hFFFFFE)), 32'd0);
        repeat (10) @(negedge iCLK);
        popSeq("wrap_pop", 24'hFFFFFE, 3);

        check("max_inflight", 32'(maxOut <= int'(MAXO)), 32'd1);
        check("max_level",    32'(maxLvl <= int'(DEPTH)), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
